// File: rtl/mbus_tx_sequencer_ice.sv
// mbus_tx_sequencer_ice
// Arbitrates two message sources onto one MBus node TX port and walks the
// node's four-phase TX handshake (TX_REQ/TX_ACK per word, then
// TX_SUCC/TX_FAIL closed with TX_RESP_ACK). A watchdog aborts a stalled
// message and reports a timeout status.

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module mbus_tx_sequencer_ice #(
  parameter int                  SYNC_STAGES = 2,
  parameter int                  TO_WIDTH    = 16,
  parameter logic [TO_WIDTH-1:0] TIMEOUT     = 16'd50000
) (
  input  logic                     CLK,
  input  logic                     RESETn,
  input  logic [1:0]               REQ_VALID,
  input  logic [2*`ADDR_WIDTH-1:0] REQ_ADDR,
  input  logic [2*`DATA_WIDTH-1:0] REQ_DATA,
  input  logic [1:0]               REQ_LAST,
  input  logic [1:0]               REQ_PRIORITY,
  output logic [1:0]               REQ_READY,
  output logic [1:0]               GRANT,
  output logic [1:0]               DONE,
  output logic [1:0]               STATUS,
  output logic                     BUSY,
  output logic [`ADDR_WIDTH-1:0]   TX_ADDR,
  output logic [`DATA_WIDTH-1:0]   TX_DATA,
  output logic                     TX_REQ,
  output logic                     TX_PEND,
  output logic                     TX_PRIORITY,
  output logic                     TX_RESP_ACK,
  input  logic                     TX_ACK,
  input  logic                     TX_SUCC,
  input  logic                     TX_FAIL
);

  localparam int AW = `ADDR_WIDTH;
  localparam int DW = `DATA_WIDTH;

  localparam logic [1:0] ST_SUCC    = 2'b00;
  localparam logic [1:0] ST_FAIL    = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_REQ,
    S_ACKLO,
    S_RESULT,
    S_RESP,
    S_ABORT
  } state_t;

  // ---------------------------------------------------------------------
  // Resynchronisers for the node's handshake inputs
  // ---------------------------------------------------------------------
  logic [2:0] async_in;
  logic [2:0] synced;
  logic       ack_s;
  logic       succ_s;
  logic       fail_s;

  assign async_in = {TX_FAIL, TX_SUCC, TX_ACK};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_sync
      logic [SYNC_STAGES-1:0] chain_reg;

      // Shift the asynchronous input through SYNC_STAGES flops.
      always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) chain_reg <= '0;
        else         chain_reg <= (chain_reg << 1) | SYNC_STAGES'(async_in[gi]);
      end

      assign synced[gi] = chain_reg[SYNC_STAGES-1];
    end
  endgenerate

  assign ack_s  = synced[0];
  assign succ_s = synced[1];
  assign fail_s = synced[2];

  // Per-requester views of the packed request buses.
  logic [AW-1:0] addr_w [2];
  logic [DW-1:0] data_w [2];

  generate
    for (gi = 0; gi < 2; gi++) begin : g_split
      assign addr_w[gi] = REQ_ADDR[gi*AW +: AW];
      assign data_w[gi] = REQ_DATA[gi*DW +: DW];
    end
  endgenerate

  // ---------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------
  state_t        state_reg, state_next;
  logic          owner_reg, owner_next;
  logic          rr_reg, rr_next;
  logic          last_reg, last_next;
  logic [1:0]    res_reg, res_next;
  logic [TO_WIDTH-1:0] wd_reg, wd_next;
  logic [1:0]    grant_reg, grant_next;
  logic [1:0]    done_reg, done_next;
  logic [1:0]    status_reg, status_next;
  logic [AW-1:0] tx_addr_reg, tx_addr_next;
  logic [DW-1:0] tx_data_reg, tx_data_next;
  logic          tx_req_reg, tx_req_next;
  logic          tx_pend_reg, tx_pend_next;
  logic          tx_pri_reg, tx_pri_next;
  logic          resp_ack_reg, resp_ack_next;
  logic [1:0]    req_ready_c;

  // Arbitration helpers
  logic [1:0]    eligible;
  logic          pick;
  logic [TO_WIDTH:0] wd_inc;
  logic          timeout_hit;
  logic          wd_counting;

  assign wd_inc      = {1'b0, wd_reg} + {{TO_WIDTH{1'b0}}, 1'b1};
  assign timeout_hit = (wd_inc >= {1'b0, TIMEOUT});

  // Priority requesters beat plain ones; equal claims go to the RR pointer.
  always_comb begin
    eligible = REQ_VALID & REQ_PRIORITY;
    if (eligible == 2'b00) eligible = REQ_VALID;
    pick = (eligible == 2'b11) ? rr_reg : eligible[1];
  end

  // Next-state and next-output logic for the handshake sequencer.
  always_comb begin
    state_next    = state_reg;
    owner_next    = owner_reg;
    rr_next       = rr_reg;
    last_next     = last_reg;
    res_next      = res_reg;
    grant_next    = grant_reg;
    done_next     = 2'b00;
    status_next   = 2'b00;
    tx_addr_next  = tx_addr_reg;
    tx_data_next  = tx_data_reg;
    tx_req_next   = tx_req_reg;
    tx_pend_next  = tx_pend_reg;
    tx_pri_next   = tx_pri_reg;
    resp_ack_next = resp_ack_reg;
    req_ready_c   = 2'b00;
    wd_counting   = 1'b0;

    case (state_reg)
      S_IDLE: begin
        // Arbitration is held off during the DONE cycle so the finishing
        // requester's stale REQ_VALID is never seen as a new message.
        if (done_reg == 2'b00 && REQ_VALID != 2'b00) begin
          owner_next   = pick;
          grant_next   = pick ? 2'b10 : 2'b01;
          tx_addr_next = addr_w[pick];
          tx_pri_next  = REQ_PRIORITY[pick];
          rr_next      = ~pick;
          state_next   = S_LOAD;
        end
      end

      S_LOAD: begin
        wd_counting = 1'b1;
        if (fail_s) begin
          res_next      = ST_FAIL;
          resp_ack_next = 1'b1;
          state_next    = S_RESP;
        end else if (REQ_VALID[owner_reg]) begin
          tx_data_next           = data_w[owner_reg];
          tx_pend_next           = ~REQ_LAST[owner_reg];
          last_next              = REQ_LAST[owner_reg];
          req_ready_c[owner_reg] = 1'b1;
          tx_req_next            = 1'b1;
          state_next             = S_REQ;
        end else if (timeout_hit) begin
          res_next   = ST_TIMEOUT;
          state_next = S_ABORT;
        end
      end

      S_REQ: begin
        wd_counting = 1'b1;
        if (fail_s) begin
          tx_req_next   = 1'b0;
          res_next      = ST_FAIL;
          resp_ack_next = 1'b1;
          state_next    = S_RESP;
        end else if (ack_s) begin
          tx_req_next = 1'b0;
          state_next  = S_ACKLO;
        end else if (timeout_hit) begin
          tx_req_next = 1'b0;
          res_next    = ST_TIMEOUT;
          state_next  = S_ABORT;
        end
      end

      S_ACKLO: begin
        wd_counting = 1'b1;
        if (fail_s) begin
          res_next      = ST_FAIL;
          resp_ack_next = 1'b1;
          state_next    = S_RESP;
        end else if (!ack_s) begin
          state_next = last_reg ? S_RESULT : S_LOAD;
        end else if (timeout_hit) begin
          res_next   = ST_TIMEOUT;
          state_next = S_ABORT;
        end
      end

      S_RESULT: begin
        wd_counting = 1'b1;
        if (succ_s || fail_s) begin
          res_next      = fail_s ? ST_FAIL : ST_SUCC;
          resp_ack_next = 1'b1;
          state_next    = S_RESP;
        end else if (timeout_hit) begin
          res_next   = ST_TIMEOUT;
          state_next = S_ABORT;
        end
      end

      S_RESP: begin
        if (!succ_s && !fail_s) begin
          resp_ack_next        = 1'b0;
          done_next[owner_reg] = 1'b1;
          status_next          = res_reg;
          grant_next           = 2'b00;
          state_next           = S_IDLE;
        end
      end

      S_ABORT: begin
        // A late result from the node is still closed out properly, but the
        // message is reported as timed out either way.
        if (!ack_s) begin
          if (succ_s || fail_s) begin
            resp_ack_next = 1'b1;
            state_next    = S_RESP;
          end else begin
            done_next[owner_reg] = 1'b1;
            status_next          = ST_TIMEOUT;
            grant_next           = 2'b00;
            state_next           = S_IDLE;
          end
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase

    // The watchdog measures time spent without a state change.
    if (state_next != state_reg) wd_next = '0;
    else if (wd_counting)        wd_next = wd_inc[TO_WIDTH-1:0];
    else                         wd_next = '0;
  end

  // Register the sequencer state and all registered outputs.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_reg    <= S_IDLE;
      owner_reg    <= 1'b0;
      rr_reg       <= 1'b0;
      last_reg     <= 1'b0;
      res_reg      <= 2'b00;
      wd_reg       <= '0;
      grant_reg    <= 2'b00;
      done_reg     <= 2'b00;
      status_reg   <= 2'b00;
      tx_addr_reg  <= '0;
      tx_data_reg  <= '0;
      tx_req_reg   <= 1'b0;
      tx_pend_reg  <= 1'b0;
      tx_pri_reg   <= 1'b0;
      resp_ack_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      owner_reg    <= owner_next;
      rr_reg       <= rr_next;
      last_reg     <= last_next;
      res_reg      <= res_next;
      wd_reg       <= wd_next;
      grant_reg    <= grant_next;
      done_reg     <= done_next;
      status_reg   <= status_next;
      tx_addr_reg  <= tx_addr_next;
      tx_data_reg  <= tx_data_next;
      tx_req_reg   <= tx_req_next;
      tx_pend_reg  <= tx_pend_next;
      tx_pri_reg   <= tx_pri_next;
      resp_ack_reg <= resp_ack_next;
    end
  end

  assign REQ_READY   = req_ready_c;
  assign GRANT       = grant_reg;
  assign DONE        = done_reg;
  assign STATUS      = status_reg;
  assign BUSY        = (state_reg != S_IDLE);
  assign TX_ADDR     = tx_addr_reg;
  assign TX_DATA     = tx_data_reg;
  assign TX_REQ      = tx_req_reg;
  assign TX_PEND     = tx_pend_reg;
  assign TX_PRIORITY = tx_pri_reg;
  assign TX_RESP_ACK = resp_ack_reg;

endmodule

// File: tb/tb_mbus_tx_sequencer_ice.sv
// Bench for mbus_tx_sequencer_ice: two requester models, a node model and a
// scoreboard of expected words, grants and completions.

module tb_mbus_tx_sequencer_ice;

  logic        CLK = 1'b0;
  logic        RESETn;
  logic [1:0]  REQ_VALID;
  logic [63:0] REQ_ADDR;
  logic [63:0] REQ_DATA;
  logic [1:0]  REQ_LAST;
  logic [1:0]  REQ_PRIORITY;
  logic [1:0]  REQ_READY;
  logic [1:0]  GRANT;
  logic [1:0]  DONE;
  logic [1:0]  STATUS;
  logic        BUSY;
  logic [31:0] TX_ADDR;
  logic [31:0] TX_DATA;
  logic        TX_REQ;
  logic        TX_PEND;
  logic        TX_PRIORITY;
  logic        TX_RESP_ACK;
  logic        TX_ACK;
  logic        TX_SUCC;
  logic        TX_FAIL;

  always #5 CLK = ~CLK;

  mbus_tx_sequencer_ice #(
    .SYNC_STAGES(2),
    .TO_WIDTH   (16),
    .TIMEOUT    (16'd20)
  ) dut (
    .CLK         (CLK),
    .RESETn      (RESETn),
    .REQ_VALID   (REQ_VALID),
    .REQ_ADDR    (REQ_ADDR),
    .REQ_DATA    (REQ_DATA),
    .REQ_LAST    (REQ_LAST),
    .REQ_PRIORITY(REQ_PRIORITY),
    .REQ_READY   (REQ_READY),
    .GRANT       (GRANT),
    .DONE        (DONE),
    .STATUS      (STATUS),
    .BUSY        (BUSY),
    .TX_ADDR     (TX_ADDR),
    .TX_DATA     (TX_DATA),
    .TX_REQ      (TX_REQ),
    .TX_PEND     (TX_PEND),
    .TX_PRIORITY (TX_PRIORITY),
    .TX_RESP_ACK (TX_RESP_ACK),
    .TX_ACK      (TX_ACK),
    .TX_SUCC     (TX_SUCC),
    .TX_FAIL     (TX_FAIL)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        last;
    logic        pri;
  } word_t;

  word_t       rq0[$];
  word_t       rq1[$];
  word_t       ex0[$];
  word_t       ex1[$];
  logic        exp_grant[$];
  logic [2:0]  exp_done[$];   // {owner, status}

  int n_checks = 0;
  int n_fail   = 0;

  int  ready_cnt[2];
  bit  started[2];
  int  resp_rises   = 0;
  int  last_req_len = 0;
  int  hi_len       = 0;
  int  node_st      = 0;
  int  node_words   = 0;
  int  fail_after   = 0;
  bit  never_ack    = 1'b0;
  bit  node_pend    = 1'b0;

  logic [1:0]  prev_grant = 2'b00;
  logic        prev_req   = 1'b0;
  logic        prev_rack  = 1'b0;
  logic [64:0] prev_vec   = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int q_size(input int r);
    return (r == 0) ? rq0.size() : rq1.size();
  endfunction

  function automatic word_t q_head(input int r);
    return (r == 0) ? rq0[0] : rq1[0];
  endfunction

  function automatic word_t q_pop(input int r);
    if (r == 0) return rq0.pop_front();
    return rq1.pop_front();
  endfunction

  // Queue a message on requester r; the first n_exp words are expected on the node.
  task automatic send(input int r, input logic [31:0] addr, input int n, input logic pri,
                      input int n_exp, input logic [31:0] d0);
    word_t w;
    for (int i = 0; i < n; i++) begin
      w.addr = addr;
      w.data = (i == 0) ? d0 : $urandom;
      w.last = (i == n - 1);
      w.pri  = pri;
      if (r == 0) rq0.push_back(w); else rq1.push_back(w);
      if (i < n_exp) begin
        if (r == 0) ex0.push_back(w); else ex1.push_back(w);
      end
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (!(rq0.size() == 0 && rq1.size() == 0 && exp_done.size() == 0 &&
             BUSY == 1'b0 && node_st == 0) && n < 3000) begin
      @(negedge CLK);
      n++;
    end
    chk({tag, "_idle"}, 64'(n < 3000), 64'd1);
    repeat (3) @(negedge CLK);
    chk({tag, "_ex0_empty"}, 64'(ex0.size()), 64'd0);
    chk({tag, "_ex1_empty"}, 64'(ex1.size()), 64'd0);
  endtask

  // Requester models: present the head word, pop it on accept, drop the
  // unsent remainder of a message when its DONE arrives.
  initial begin
    word_t w;
    REQ_VALID    = 2'b00;
    REQ_ADDR     = '0;
    REQ_DATA     = '0;
    REQ_LAST     = 2'b00;
    REQ_PRIORITY = 2'b00;
    ready_cnt[0] = 0;
    ready_cnt[1] = 0;
    started[0]   = 1'b0;
    started[1]   = 1'b0;
    forever begin
      @(negedge CLK);
      for (int r = 0; r < 2; r++) begin
        if (RESETn && q_size(r) > 0) begin
          w = q_head(r);
          REQ_VALID[r]        = 1'b1;
          REQ_ADDR[r*32 +: 32] = w.addr;
          REQ_DATA[r*32 +: 32] = w.data;
          REQ_LAST[r]         = w.last;
          REQ_PRIORITY[r]     = w.pri;
        end else begin
          REQ_VALID[r]    = 1'b0;
          REQ_LAST[r]     = 1'b0;
          REQ_PRIORITY[r] = 1'b0;
        end
      end
      #4;
      for (int r = 0; r < 2; r++) begin
        if (RESETn && REQ_VALID[r] && REQ_READY[r]) begin
          w = q_pop(r);
          ready_cnt[r]++;
          started[r] = !w.last;
        end
        if (RESETn && DONE[r] && started[r]) begin
          while (q_size(r) > 0) begin
            w = q_pop(r);
            if (w.last) break;
          end
          started[r] = 1'b0;
        end
      end
    end
  end

  // Node model: checks each word as TX_REQ rises, ACKs it, and ends the
  // message with SUCC (or FAIL after word fail_after).
  initial begin
    word_t w;
    TX_ACK  = 1'b0;
    TX_SUCC = 1'b0;
    TX_FAIL = 1'b0;
    forever begin
      @(negedge CLK);
      if (!RESETn) begin
        TX_ACK = 1'b0; TX_SUCC = 1'b0; TX_FAIL = 1'b0;
        node_st = 0; node_words = 0;
      end else begin
        case (node_st)
          0: if (TX_REQ) begin
            node_words++;
            if ((GRANT[1] ? ex1.size() : ex0.size()) == 0) begin
              chk("node_unexpected_word", {TX_ADDR, TX_DATA}, 64'd0);
            end else begin
              w = GRANT[1] ? ex1.pop_front() : ex0.pop_front();
              chk("tx_addr", TX_ADDR, w.addr);
              chk("tx_data", TX_DATA, w.data);
              chk("tx_pend", TX_PEND, !w.last);
              chk("tx_pri", TX_PRIORITY, w.pri);
            end
            node_pend = TX_PEND;
            if (never_ack) node_st = 5;
            else begin TX_ACK = 1'b1; node_st = 1; end
          end
          1: if (!TX_REQ) begin
            TX_ACK = 1'b0;
            if (fail_after != 0 && node_words == fail_after) begin
              TX_FAIL = 1'b1; node_st = 3;
            end else if (!node_pend) begin
              TX_SUCC = 1'b1; node_st = 3;
            end else node_st = 0;
          end
          3: if (TX_RESP_ACK) begin
            TX_SUCC = 1'b0; TX_FAIL = 1'b0; node_st = 4;
          end
          4: if (!TX_RESP_ACK) begin node_st = 0; node_words = 0; end
          5: if (!TX_REQ) begin node_st = 0; node_words = 0; end
          default: node_st = 0;
        endcase
      end
    end
  end

  // Output monitor: grant order, completions, TX stability, pulse counts.
  initial begin
    logic       g;
    logic [2:0] d;
    forever begin
      @(negedge CLK);
      if (!RESETn) begin
        prev_grant = 2'b00; prev_req = 1'b0; prev_rack = 1'b0; hi_len = 0;
      end else begin
        if (GRANT != 2'b00 && prev_grant == 2'b00) begin
          if (exp_grant.size() == 0) chk("grant_unexpected", 64'(GRANT), 64'd0);
          else begin
            g = exp_grant.pop_front();
            chk("grant", 64'(GRANT), g ? 64'd2 : 64'd1);
          end
        end
        if (DONE != 2'b00) begin
          if (exp_done.size() == 0) chk("done_unexpected", 64'(DONE), 64'd0);
          else begin
            d = exp_done.pop_front();
            chk("done", 64'(DONE), d[2] ? 64'd2 : 64'd1);
            chk("status", 64'(STATUS), 64'(d[1:0]));
          end
        end
        if (TX_REQ && prev_req)
          chk("tx_stable", {TX_ADDR, TX_DATA}, prev_vec[64:1]);
        if (TX_REQ) hi_len++;
        else if (prev_req) begin last_req_len = hi_len; hi_len = 0; end
        if (TX_RESP_ACK && !prev_rack) resp_rises++;
        prev_grant = GRANT;
        prev_req   = TX_REQ;
        prev_rack  = TX_RESP_ACK;
        prev_vec   = {TX_ADDR, TX_DATA, TX_PEND};
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "global timeout");
  end

  initial begin
    int rc0, rc1, rr0, n;

    RESETn = 1'b0;
    repeat (4) @(negedge CLK);
    chk("rst_grant", 64'(GRANT), 64'd0);
    chk("rst_busy_done_status", {BUSY, DONE, STATUS}, 64'd0);
    chk("rst_tx_ctrl", {TX_REQ, TX_PEND, TX_PRIORITY, TX_RESP_ACK, REQ_READY}, 64'd0);
    chk("rst_tx_bus", {TX_ADDR, TX_DATA}, 64'd0);
    RESETn = 1'b1;
    @(negedge CLK);

    // Single word from r0
    rc0 = ready_cnt[0]; rr0 = resp_rises;
    exp_grant.push_back(1'b0);
    exp_done.push_back(3'b000);
    send(0, 32'h0000_0050, 1, 1'b0, 1, 32'hA5A5_A5A5);
    wait_idle("t1");
    chk("t1_ready", 64'(ready_cnt[0] - rc0), 64'd1);
    chk("t1_respack", 64'(resp_rises - rr0), 64'd1);
    chk("t1_busy", 64'(BUSY), 64'd0);

    // Three-word message from r1
    rc1 = ready_cnt[1];
    exp_grant.push_back(1'b1);
    exp_done.push_back(3'b100);
    send(1, 32'h1234_5678, 3, 1'b0, 3, 32'h0BAD_CAFE);
    wait_idle("t2");
    chk("t2_ready", 64'(ready_cnt[1] - rc1), 64'd3);

    // Round-robin with both valid, then a priority claim against the pointer
    rc0 = ready_cnt[0]; rc1 = ready_cnt[1];
    for (int i = 0; i < 4; i++) begin
      exp_grant.push_back(1'b0); exp_done.push_back(3'b000);
      exp_grant.push_back(1'b1); exp_done.push_back(3'b100);
    end
    for (int i = 0; i < 4; i++) begin
      send(0, 32'h0000_1000 + 32'(i), 1 + (i % 2), 1'b0, 1 + (i % 2), $urandom);
      send(1, 32'h0000_2000 + 32'(i), 1 + ((i + 1) % 2), 1'b0, 1 + ((i + 1) % 2), $urandom);
    end
    wait_idle("t3_rr");
    chk("t3_ready0", 64'(ready_cnt[0] - rc0), 64'd6);
    chk("t3_ready1", 64'(ready_cnt[1] - rc1), 64'd6);
    exp_grant.push_back(1'b1); exp_done.push_back(3'b100);
    exp_grant.push_back(1'b0); exp_done.push_back(3'b000);
    send(0, 32'h0000_3000, 1, 1'b0, 1, 32'h1111_1111);
    send(1, 32'h0000_3001, 1, 1'b1, 1, 32'h2222_2222);
    wait_idle("t3_pri");

    // Node fails after the first word of three
    rc0 = ready_cnt[0]; rr0 = resp_rises;
    fail_after = 1;
    exp_grant.push_back(1'b0);
    exp_done.push_back(3'b001);
    send(0, 32'h0000_4000, 3, 1'b0, 1, 32'h3333_3333);
    wait_idle("t4");
    fail_after = 0;
    chk("t4_ready", 64'(ready_cnt[0] - rc0), 64'd1);
    chk("t4_respack", 64'(resp_rises - rr0), 64'd1);

    // Node never ACKs: watchdog abort after TIMEOUT cycles of TX_REQ
    never_ack = 1'b1;
    rr0 = resp_rises;
    exp_grant.push_back(1'b0);
    exp_done.push_back(3'b010);
    send(0, 32'h0000_5000, 1, 1'b0, 1, 32'h4444_4444);
    wait_idle("t5");
    chk("t5_req_len", 64'(last_req_len), 64'd20);
    chk("t5_busy", 64'(BUSY), 64'd0);
    chk("t5_respack", 64'(resp_rises - rr0), 64'd0);

    // Reset in the middle of REQ, then a normal message
    exp_grant.push_back(1'b1);
    send(1, 32'h0000_6000, 1, 1'b1, 1, 32'h5555_5555);
    n = 0;
    while (!TX_REQ && n < 200) begin @(negedge CLK); n++; end
    chk("t6_reached_req", 64'(TX_REQ), 64'd1);
    repeat (3) @(posedge CLK);
    #2 RESETn = 1'b0;
    #1;
    chk("t6_rst_grant_busy", {GRANT, BUSY, DONE, STATUS}, 64'd0);
    chk("t6_rst_tx_ctrl", {TX_REQ, TX_PEND, TX_PRIORITY, TX_RESP_ACK, REQ_READY}, 64'd0);
    chk("t6_rst_tx_bus", {TX_ADDR, TX_DATA}, 64'd0);
    rq0.delete(); rq1.delete(); ex0.delete(); ex1.delete();
    exp_grant.delete(); exp_done.delete();
    started[0] = 1'b0; started[1] = 1'b0;
    never_ack = 1'b0;
    repeat (3) @(negedge CLK);
    RESETn = 1'b1;
    @(negedge CLK);
    exp_grant.push_back(1'b1);
    exp_done.push_back(3'b100);
    send(1, 32'h0000_7000, 2, 1'b0, 2, 32'h6666_6666);
    wait_idle("t6_after");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mbus_tx_sequencer_ice.md
Name: mbus_tx_sequencer_ice

Overview:
- Shares the single MBus node TX port between two message sources (host command path, internal ICE logic).
- Sequences the node's four-phase TX handshake: TX_REQ/TX_ACK per word, then TX_SUCC/TX_FAIL with TX_RESP_ACK.
- Sits between the ICE message sources and the TX_* pins of the MBus layer wrapper.
- Runs on the ICE system clock; the node's TX handshake inputs are resynchronised internally.

Parameters:
- SYNC_STAGES, 2, flop stages on TX_ACK, TX_SUCC and TX_FAIL.
- TO_WIDTH, 16, width of the watchdog counter.
- TIMEOUT, 16'd50000, cycles without handshake progress before abort.

Ports:
- CLK  in  1  system clock
- RESETn  in  1  reset, asynchronous, active-low
- REQ_VALID  in  2  per-requester word valid
- REQ_ADDR  in  2*`ADDR_WIDTH  {r1,r0} destination; sampled on grant
- REQ_DATA  in  2*`DATA_WIDTH  {r1,r0} data word
- REQ_LAST  in  2  word is last of message
- REQ_PRIORITY  in  2  priority message request; sampled on grant
- REQ_READY  out  2  one-cycle word-accept pulse
- GRANT  out  2  one-hot owner of the TX port
- DONE  out  2  one-cycle message-complete pulse
- STATUS  out  2  valid with DONE: 00 succ, 01 fail, 10 timeout
- BUSY  out  1  state != IDLE
- TX_ADDR  out  `ADDR_WIDTH  to node
- TX_DATA  out  `DATA_WIDTH  to node
- TX_REQ  out  1  to node
- TX_PEND  out  1  to node
- TX_PRIORITY  out  1  to node
- TX_RESP_ACK  out  1  to node
- TX_ACK  in  1  from node (async)
- TX_SUCC  in  1  from node (async)
- TX_FAIL  in  1  from node (async)

Behaviour:
- Reset (async, any state): all outputs 0, state IDLE, RR pointer favours r0, watchdog 0.
- Sync: ack_s, succ_s, fail_s are SYNC_STAGES-flop copies of the inputs. All decisions use the synced copies only.
- IDLE, arbitration:
  - Candidates are requesters with REQ_VALID=1.
  - A candidate with REQ_PRIORITY=1 beats one without.
  - Ties go round-robin. The pointer flips to the other requester after each grant.
  - On grant: latch TX_ADDR and TX_PRIORITY, set GRANT, go to LOAD.
- LOAD:
  - Wait REQ_VALID[g].
  - Then latch TX_DATA, set TX_PEND=~REQ_LAST[g], remember last, pulse REQ_READY[g] for 1 cycle, go to REQ next cycle.
- REQ: TX_REQ=1. On ack_s=1, go to ACKLO with TX_REQ=0.
- ACKLO: wait ack_s=0. Then go to RESULT if last, else LOAD.
- RESULT: wait succ_s|fail_s, then go to RESP with status = fail_s ? 01 : 00.
- RESP: TX_RESP_ACK=1. When succ_s=0 and fail_s=0: TX_RESP_ACK=0, DONE[g] pulses 1 cycle with STATUS, GRANT=0, go to IDLE.
- Early fail: fail_s=1 in LOAD, REQ or ACKLO → TX_REQ=0, go to RESP, status 01.
  - Any unaccepted words are abandoned. The requester discards the rest of its message on DONE.
- Watchdog:
  - Counts in LOAD, REQ, ACKLO and RESULT; clears on every state change.
  - At TIMEOUT: TX_REQ=0, go to ABORT.
- ABORT:
  - Wait ack_s=0.
  - If succ_s|fail_s is seen, run the RESP handshake but report status 10.
  - Then DONE with status 10.
- Latency:
  - IDLE→TX_REQ high: 2 cycles (grant, LOAD).
  - Word-to-word: ACKLO exit + LOAD + 1 cycle.
- Timing rules:
  - TX_ADDR, TX_DATA and TX_PEND are stable whenever TX_REQ=1.
  - REQ_READY never pulses outside LOAD.
  - DONE goes high for exactly one cycle per granted message.
- Simultaneous events:
  - succ_s and fail_s both high → fail wins.
  - The requester's own REQ_VALID is ignored until after its DONE cycle.
  - Back-to-back grant is possible the cycle after DONE.

Test Plan:
- Single word r0 (ADDR=0x00000050, DATA=0xA5A5A5A5, LAST=1), node ACK then SUCC → TX_REQ 1 then 0, TX_PEND=0, TX_RESP_ACK handshake, DONE=01 with STATUS=00.
- 3-word r1 message → TX_PEND=1,1,0; three REQ_READY pulses; data order preserved; DONE[1].
- Both valid in IDLE, no priority, 4 messages each → grants alternate r0,r1,r0,… Then r1 with REQ_PRIORITY=1 against r0 → r1 granted, TX_PRIORITY=1.
- TX_FAIL after word 1 of a 3-word message → TX_REQ drops, RESP handshake, STATUS=01, no further REQ_READY.
- TIMEOUT=20, node never ACKs → TX_REQ drops at cycle 20, DONE with STATUS=10, BUSY=0.
- RESETn low mid-REQ → all outputs 0 immediately; after release, a new message completes normally.
